psr_cond_unit: RTL

//  Processor status register stage directly downstream of the 16-bit ALU.
//  - Captures ALU flags C, F, N, Z, L under per-group write enables.
//  - Holds them in a CR16-layout PSR and evaluates the 4-bit branch/jump condition field.
//  - Supplies a small PSR save/restore stack for interrupt entry and return.

---
 rtl/psr_cond_unit_pkg.sv | 60 ++++++
 rtl/psr_cond_unit_if.sv | 30 +++
 rtl/psr_cond_unit_save_stack.sv | 69 ++++++
 rtl/psr_cond_unit.sv | 87 ++++++++
 4 files changed

// File: rtl/psr_cond_unit_pkg.sv
// Shared CPU definitions: PSR flag positions, condition codes, flag struct and
// the condition evaluator used by both this unit and the instruction decoder.
package cpu_pkg;

  localparam int PSR_C = 0;
  localparam int PSR_L = 2;
  localparam int PSR_F = 5;
  localparam int PSR_Z = 6;
  localparam int PSR_N = 7;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_HI = 4'h4;
  localparam logic [3:0] COND_LS = 4'h5;
  localparam logic [3:0] COND_GT = 4'h6;
  localparam logic [3:0] COND_LE = 4'h7;
  localparam logic [3:0] COND_FS = 4'h8;
  localparam logic [3:0] COND_FC = 4'h9;
  localparam logic [3:0] COND_LO = 4'hA;
  localparam logic [3:0] COND_HS = 4'hB;
  localparam logic [3:0] COND_LT = 4'hC;
  localparam logic [3:0] COND_GE = 4'hD;
  localparam logic [3:0] COND_UC = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef struct packed {
    logic n;
    logic z;
    logic f;
    logic l;
    logic c;
  } psr_flags_t;

  function automatic logic cond_eval(input logic [3:0] cc, input psr_flags_t fl);
    logic r;
    r = 1'b0;
    case (cc)
      COND_EQ: r = fl.z;
      COND_NE: r = !fl.z;
      COND_CS: r = fl.c;
      COND_CC: r = !fl.c;
      COND_HI: r = fl.l;
      COND_LS: r = !fl.l;
      COND_GT: r = fl.n;
      COND_LE: r = !fl.n;
      COND_FS: r = fl.f;
      COND_FC: r = !fl.f;
      COND_LO: r = !fl.l && !fl.z;
      COND_HS: r = fl.l || fl.z;
      COND_LT: r = !fl.n && !fl.z;
      COND_GE: r = fl.n || fl.z;
      COND_UC: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/psr_cond_unit_if.sv
// Bus between the ALU/decoder side (master) and the PSR condition unit (slave).
interface psr_cond_unit_if #(parameter int WIDTH = 16);
  logic             alu_c;
  logic             alu_f;
  logic [2:0]       alu_nzl;
  logic             we_cf;
  logic             we_nzl;
  logic             psr_wr_en;
  logic [WIDTH-1:0] psr_wr_data;
  logic             psr_push;
  logic             psr_pop;
  logic [3:0]       cond_code;
  logic [WIDTH-1:0] psr_out;
  logic             cond_true;
  logic             stk_full;
  logic             stk_empty;
  logic             stk_err;

  modport master (
    output alu_c, alu_f, alu_nzl, we_cf, we_nzl, psr_wr_en, psr_wr_data,
           psr_push, psr_pop, cond_code,
    input  psr_out, cond_true, stk_full, stk_empty, stk_err
  );

  modport slave (
    input  alu_c, alu_f, alu_nzl, we_cf, we_nzl, psr_wr_en, psr_wr_data,
           psr_push, psr_pop, cond_code,
    output psr_out, cond_true, stk_full, stk_empty, stk_err
  );
endinterface

// File: rtl/psr_cond_unit_save_stack.sv
// LIFO of PSR flag sets for interrupt entry/return. Simultaneous push and pop
// cancel out; push-when-full and pop-when-empty are dropped and set a sticky error.
module psr_save_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic       pop_i,
  input  psr_flags_t data_i,
  output psr_flags_t data_o,
  output logic       pop_ok_o,
  output logic       full_o,
  output logic       empty_o,
  output logic       err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_PTR = (AW+1)'(DEPTH);

  logic [AW:0]   ptr_q, ptr_d;
  logic          full_q, empty_q, err_q, err_d;
  logic          push_ok;
  logic [AW-1:0] top_idx;
  psr_flags_t    mem_q [DEPTH];

  assign push_ok  = push_i && !pop_i && !full_q;
  assign pop_ok_o = pop_i && !push_i && !empty_q;
  assign top_idx  = ptr_q[AW-1:0] - AW'(1);
  assign data_o   = mem_q[top_idx];

  always_comb begin
    ptr_d = ptr_q;
    if (push_ok)
      ptr_d = ptr_q + (AW+1)'(1);
    else if (pop_ok_o)
      ptr_d = ptr_q - (AW+1)'(1);
    err_d = err_q
          | (push_i && !pop_i && full_q)
          | (pop_i && !push_i && empty_q);
  end

  // Flags derive from the next pointer so they are valid the cycle after the op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      full_q  <= (ptr_d == FULL_PTR);
      empty_q <= (ptr_d == '0);
      err_q   <= err_d;
    end
  end

  // Contents are don't-care after reset, so the storage carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[ptr_q[AW-1:0]] <= data_i;
  end

  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign err_o   = err_q;

endmodule

// File: rtl/psr_cond_unit.sv
// CR16-style PSR stage after the ALU: flag capture, condition evaluation and
// PSR save stack. Define FLAG_BYPASS_EN to evaluate conditions on next-cycle flags.
module psr_cond_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int STK_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  psr_cond_unit_if.slave bus
);
  psr_flags_t       flags_q, flags_d, stk_top;
  logic             stk_pop_ok, stk_full, stk_empty, stk_err;
  logic             unused_wr;
  logic [WIDTH-1:0] psr_word;

  psr_save_stack #(.DEPTH(STK_DEPTH)) u_stack (
    .clk      (clk),
    .reset    (reset),
    .push_i   (bus.psr_push),
    .pop_i    (bus.psr_pop),
    .data_i   (flags_q),
    .data_o   (stk_top),
    .pop_ok_o (stk_pop_ok),
    .full_o   (stk_full),
    .empty_o  (stk_empty),
    .err_o    (stk_err)
  );

  // Priority: push+pop cancels everything, then pop, then LPR, then ALU flags.
  always_comb begin
    flags_d = flags_q;
    if (bus.psr_push && bus.psr_pop) begin
      flags_d = flags_q;
    end else if (stk_pop_ok) begin
      flags_d = stk_top;
    end else if (bus.psr_wr_en) begin
      flags_d.c = bus.psr_wr_data[PSR_C];
      flags_d.l = bus.psr_wr_data[PSR_L];
      flags_d.f = bus.psr_wr_data[PSR_F];
      flags_d.z = bus.psr_wr_data[PSR_Z];
      flags_d.n = bus.psr_wr_data[PSR_N];
    end else begin
      if (bus.we_cf) begin
        flags_d.c = bus.alu_c;
        flags_d.f = bus.alu_f;
      end
      if (bus.we_nzl) begin
        flags_d.n = bus.alu_nzl[2];
        flags_d.z = bus.alu_nzl[1];
        flags_d.l = bus.alu_nzl[0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      flags_q <= '0;
    else
      flags_q <= flags_d;
  end

  always_comb begin
    psr_word        = '0;
    psr_word[PSR_C] = flags_q.c;
    psr_word[PSR_L] = flags_q.l;
    psr_word[PSR_F] = flags_q.f;
    psr_word[PSR_Z] = flags_q.z;
    psr_word[PSR_N] = flags_q.n;
  end

  // Non-flag bits of the LPR value are intentionally discarded.
  assign unused_wr = ^bus.psr_wr_data;

  assign bus.psr_out   = psr_word;
  assign bus.stk_full  = stk_full;
  assign bus.stk_empty = stk_empty;
  assign bus.stk_err   = stk_err;

`ifdef FLAG_BYPASS_EN
  assign bus.cond_true = cond_eval(bus.cond_code, flags_d);
`else
  assign bus.cond_true = cond_eval(bus.cond_code, flags_q);
`endif

endmodule
